mem_arbiter: RTL and testbench

- Sits directly downstream of the i/d cache pair; consumes their word-level memory requests and drives the single RAM port.
- Arbitrates instruction vs data traffic with data priority and a starvation guard.
- Holds each grant until RAM completes the access.
- Returns load data and wait handshakes to each cache.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types.
//   word_t      : data/address word
//   ramstate_t  : RAM port status as reported by the memory
//   arb_state_t : mem_arbiter grant state
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and dcache.
// Data requests win, except that after STARVE_LIMIT consecutive D grants
// with an I request waiting the next grant goes to I. A grant is held until
// the RAM reports ACCESS (completion) or the owner withdraws its request.
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN, iaddr            icache read request / word address
//   iwait, iload           low for the completing cycle / read data
//   dREN, dWEN, daddr,     dcache read/write request, address, write data
//   dstore
//   dwait, dload           low for the completing cycle / read data
//   ramREN, ramWEN,        RAM strobes, address, write data
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data / status
//   memerr                 sticky: ERROR seen while a grant was held
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          memerr_q, memerr_d;

  logic dreq, done;
  assign dreq = dREN | dWEN;
  assign done = (ramstate == ACCESS);

  // Read data is passed straight through; it only means something while
  // the matching wait is low.
  assign iload  = ramload;
  assign dload  = ramload;
  assign memerr = memerr_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    memerr_d = memerr_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && starve_q == LIMIT)) state_d = DGRANT;
        else if (iREN)                            state_d = IGRANT;
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;          // write wins when both are set
        if (ramstate == ERROR) memerr_d = 1'b1;
        if (done) begin
          dwait   = 1'b0;
          state_d = IDLE;
          // Count back-to-back D wins only while I is actually waiting.
          if (!iREN)                 starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
        end else if (!dreq) begin
          state_d = IDLE;                 // withdrawn: strobes already low
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (ramstate == ERROR) memerr_d = 1'b1;
        if (done) begin
          iwait    = 1'b0;
          state_d  = IDLE;
          starve_d = '0;
        end else if (!iREN) begin
          ramREN  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      memerr_q <= memerr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model of who owns
// the RAM port is compared against the DUT on every falling edge, and
// directed scenarios pin the model with hand-computed literals.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN, memerr;
  word_t     iload, dload, ramaddr, ramstore;

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  // ---------------- model: owner 0=none, 1=dcache, 2=icache ----------------
  int m_own = 0, m_starve = 0;
  bit m_err = 0;
  int n_own = 0, n_starve = 0;
  bit n_err = 0;

  always @(negedge CLK) begin
    logic        e_iw, e_dw, e_ren, e_wen, dreq, fin;
    word_t       e_addr, e_st;
    logic [68:0] e_vec, a_vec;
    if (!nRST) begin m_own = 0; m_starve = 0; m_err = 0; end
    e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_addr = '0; e_st = '0;
    n_own = m_own; n_starve = m_starve; n_err = m_err;
    dreq = dREN | dWEN;
    fin  = (ramstate == ACCESS);
    if (m_own == 0) begin
      if (dreq && !(iREN && m_starve == LIM)) n_own = 1;
      else if (iREN)                          n_own = 2;
    end else if (m_own == 1) begin
      e_addr = daddr; e_st = dstore;
      e_wen = dWEN; e_ren = dREN & ~dWEN;
      if (ramstate == ERROR) n_err = 1;
      if (fin) begin
        e_dw = 0; n_own = 0;
        n_starve = iREN ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      end else if (!dreq) n_own = 0;
    end else begin
      e_addr = iaddr; e_ren = iREN | fin;
      if (ramstate == ERROR) n_err = 1;
      if (fin) begin e_iw = 0; n_own = 0; n_starve = 0; end
      else if (!iREN) n_own = 0;
    end
    if (!nRST) begin n_own = 0; n_starve = 0; n_err = 0; end

    e_vec = {e_iw, e_dw, e_ren, e_wen, m_err, e_addr, e_st};
    a_vec = {iwait, dwait, ramREN, ramWEN, memerr, ramaddr, ramstore};
    checks++;
    if (a_vec !== e_vec) begin
      fails++;
      $display("FAIL model_cycle t=%0t act{iw,dw,ren,wen,err,addr,st}=%h exp=%h",
               $time, a_vec, e_vec);
    end
    if (!e_iw) begin
      checks++;
      if (iload !== ramload) begin
        fails++;
        $display("FAIL model_iload act=%h exp=%h", iload, ramload);
      end
    end
    if (!e_dw) begin
      checks++;
      if (dload !== ramload) begin
        fails++;
        $display("FAIL model_dload act=%h exp=%h", dload, ramload);
      end
    end
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin m_own = 0; m_starve = 0; m_err = 0; end
    else begin m_own = n_own; m_starve = n_starve; m_err = n_err; end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  int seq[$];

  initial begin
    // reset state
    #1;
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_strobes", {30'd0, ramREN, ramWEN}, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_memerr", 32'(memerr), 0);
    tick(); nRST = 1'b1;

    // lone I read
    tick(); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    chk("i_idle_ren", 32'(ramREN), 0);
    tick(); ramstate = BUSY; #1;
    chk("i_grant_ren", 32'(ramREN), 1);
    chk("i_grant_addr", ramaddr, 32'h40);
    chk("i_grant_wait", 32'(iwait), 1);
    tick(); ramstate = ACCESS; ramload = 32'h8C220004; #1;
    chk("i_done_wait", 32'(iwait), 0);
    chk("i_done_load", iload, 32'h8C220004);
    tick(); iREN = 0; ramstate = FREE; #1;
    chk("i_after_wait", 32'(iwait), 1);
    chk("i_after_ren", 32'(ramREN), 0);

    // simultaneous I and D: D first, bubble, then I
    tick(); iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200; #1;
    tick(); #1;
    chk("sim_d_addr", ramaddr, 32'h200);
    ramstate = ACCESS; ramload = 32'h11112222; #1;
    chk("sim_d_wait", 32'(dwait), 0);
    chk("sim_i_noglitch", 32'(iwait), 1);
    chk("sim_d_load", dload, 32'h11112222);
    tick(); dREN = 0; ramstate = FREE; #1;
    chk("sim_bubble_ren", 32'(ramREN), 0);
    tick(); #1;
    chk("sim_i_addr", ramaddr, 32'h44);
    ramstate = ACCESS; #1;
    chk("sim_i_wait", 32'(iwait), 0);
    chk("sim_d_noglitch", 32'(dwait), 1);
    tick(); iREN = 0; ramstate = FREE;

    // starvation: RAM always ready, both requests held
    tick(); dREN = 1; iREN = 1; ramstate = ACCESS;
    for (int c = 0; c < 24; c++) begin
      tick(); #1;
      if (!dwait) seq.push_back(1);
      if (!iwait) seq.push_back(2);
    end
    chk("starve_count", seq.size(), 12);
    if (seq.size() >= 10) begin
      for (int k = 0; k < 10; k++)
        chk($sformatf("starve_seq%0d", k), seq[k], (k % 5 == 4) ? 2 : 1);
    end
    tick(); dREN = 0; iREN = 0; ramstate = FREE;

    // write with both strobes
    tick(); dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick(); #1;
    chk("wr_wen", 32'(ramWEN), 1);
    chk("wr_ren", 32'(ramREN), 0);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    chk("wr_addr", ramaddr, 32'h100);
    chk("wr_wait_pre", 32'(dwait), 1);
    ramstate = ACCESS; #1;
    chk("wr_wait_done", 32'(dwait), 0);
    tick(); dWEN = 0; dREN = 0; ramstate = FREE;

    // error then abort
    tick(); dREN = 1; daddr = 32'h300;
    tick(); ramstate = ERROR; #1;
    chk("err_wait", 32'(dwait), 1);
    tick(); #1;
    chk("err_memerr", 32'(memerr), 1);
    chk("err_held_ren", 32'(ramREN), 1);
    chk("err_held_wait", 32'(dwait), 1);
    dREN = 0; #1;
    chk("abort_ren", 32'(ramREN), 0);
    chk("abort_wait", 32'(dwait), 1);
    tick(); ramstate = FREE; #1;
    chk("abort_idle_addr", ramaddr, 0);
    tick(); tick(); #1;
    chk("err_sticky", 32'(memerr), 1);

    // reset mid-IGRANT
    tick(); iREN = 1; iaddr = 32'h80; ramstate = BUSY;
    tick(); #1;
    chk("rst2_pre_ren", 32'(ramREN), 1);
    nRST = 0; #1;
    chk("rst2_iwait", 32'(iwait), 1);
    chk("rst2_ren", 32'(ramREN), 0);
    chk("rst2_memerr", 32'(memerr), 0);
    iREN = 0;
    tick(); nRST = 1;
    tick(); iREN = 1; #1;
    chk("rst2_idle_ren", 32'(ramREN), 0);
    tick(); #1;
    chk("rst2_grant_addr", ramaddr, 32'h80);
    iREN = 0; ramstate = FREE;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
